// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the 5-input truth-table scanner.
// Sizes are fixed by the 32-vector sweep; SETTLE_MAX bounds the per-vector wait.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 32;
  localparam int IDX_W       = 5;
  localparam int CNT_W       = 6;
  localparam int SETTLE_MAX  = 15;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner and its controller / function under test.
// master drives start, golden table and the function output; slave is the scanner.
interface tt_scan_if;

  logic                                start;
  logic [tt_scan_pkg::NUM_VECTORS-1:0] expected;
  logic [tt_scan_pkg::IDX_W-1:0]       dut_in;
  logic                                dut_out;
  logic                                busy;
  logic                                done;
  logic [tt_scan_pkg::NUM_VECTORS-1:0] table_out;
  logic [5:0]                          mismatch_count;
  logic                                pass;
  logic [tt_scan_pkg::IDX_W-1:0]       first_bad;
  logic                                first_bad_valid;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, table_out, mismatch_count, pass,
           first_bad, first_bad_valid
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, table_out, mismatch_count, pass,
           first_bad, first_bad_valid
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter: strobes sample once every settle+1 enabled cycles.
// Reloads on terminal count so consecutive vectors need no extra cycle.
module tt_settle_timer
  import tt_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] settle,
  output logic             sample
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= settle;
    end else if (en) begin
      if (cnt_q == '0) cnt_q <= settle;
      else             cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign sample = en && (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 32 inputs of a 5-input function, captures its truth table and compares to a golden table.
// Define MISMATCH_CAPTURE_EN to record the lowest failing index on first_bad/first_bad_valid.
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic        clk,
  input logic        reset,
  tt_scan_if.slave   bus
);

  // state | meaning
  // IDLE  | waiting for start; results from the last scan held
  // RUN   | driving dut_in=idx, sampling dut_out every SETTLE_CYCLES+1 cycles
  // DONE  | one-cycle completion pulse, pass valid

  localparam int SETTLE_EFF = (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [NUM_VECTORS-1:0] table_q;
  logic [5:0]             mc_q;
  logic                   pass_q;
  logic                   accept;
  logic                   sample;
  logic                   last_sample;
  logic                   bit_bad;

  assign accept      = (state_q == IDLE) && bus.start;
  assign last_sample = sample && (idx_q == IDX_W'(NUM_VECTORS - 1));
  assign bit_bad     = bus.dut_out != exp_q[idx_q];

  tt_settle_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .en     (state_q == RUN),
    .settle (CNT_W'(SETTLE_EFF)),
    .sample (sample)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_sample) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mc_q    <= '0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      exp_q   <= bus.expected;
      table_q <= '0;
      mc_q    <= '0;
      pass_q  <= 1'b0;
    end else if (sample) begin
      table_q[idx_q] <= bus.dut_out;
      idx_q          <= idx_q + IDX_W'(1);
      if (bit_bad) mc_q <= mc_q + 6'd1;
      // Include the final sample's own verdict, which mc_q has not yet absorbed.
      if (last_sample) pass_q <= (mc_q == 6'd0) && !bit_bad;
    end
  end

`ifdef MISMATCH_CAPTURE_EN
  logic [IDX_W-1:0] fb_q;
  logic             fbv_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      fb_q  <= '0;
      fbv_q <= 1'b0;
    end else if (sample && bit_bad && !fbv_q) begin
      fb_q  <= idx_q;
      fbv_q <= 1'b1;
    end
  end

  assign bus.first_bad       = fb_q;
  assign bus.first_bad_valid = fbv_q;
`else
  assign bus.first_bad       = '0;
  assign bus.first_bad_valid = 1'b0;
`endif

  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.dut_in         = (state_q == RUN) ? idx_q : '0;
  assign bus.table_out      = table_q;
  assign bus.mismatch_count = mc_q;
  assign bus.pass           = pass_q;

endmodule
